// File: rtl/sobel_pkg.sv
// Sobel window stage: shared widths, saturation
// limit and 3x2 window type.
package sobel_pkg;

  localparam int DATA_W_DFLT = 16;
  localparam int GRAD_W      = 20;

  localparam logic [DATA_W_DFLT-1:0] SAT_MAX = '1;

  typedef logic [DATA_W_DFLT-1:0] pix_t;
  typedef pix_t win_t [3][2];
  typedef logic signed [GRAD_W-1:0] grad_t;

endpackage

// File: rtl/sobel_window_stage_if.sv
// Column stream in, gradient stream out.
// No backpressure in either direction.
interface sobel_window_stage_if
  import sobel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
);

  logic              valid_in;
  logic [DATA_W-1:0] row0_in;
  logic [DATA_W-1:0] row1_in;
  logic [DATA_W-1:0] row2_in;
  logic              valid_out;
  logic [DATA_W-1:0] data_out;
  logic              frame_done;

  modport master (
    output valid_in, row0_in,
    output row1_in, row2_in,
    input  valid_out, data_out,
    input  frame_done
  );

  modport slave (
    input  valid_in, row0_in,
    input  row1_in, row2_in,
    output valid_out, data_out,
    output frame_done
  );

endinterface

// File: rtl/sobel_grad_core.sv
// Sobel gx/gy arithmetic (stage 1) and
// saturated |gx|+|gy| (stage 2).
module sobel_grad_core
  import sobel_pkg::*;
#(
  parameter int DATA_W = DATA_W_DFLT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic              last_i,
  input  win_t              win_i,
  input  pix_t              col_i [3],
  output logic              valid_o,
  output logic [DATA_W-1:0] data_o,
  output logic              frame_done_o
);

  pix_t              p [3][3];
  grad_t             gx_d, gy_d;
  grad_t             gx_q, gy_q;
  logic [GRAD_W-1:0] ax, ay;
  logic [GRAD_W:0]   sum;
  logic [DATA_W-1:0] data_d, data_q;
  logic              v1_q, l1_q;
  logic              v2_q, fd_q;

  function automatic grad_t px(input pix_t v);
    return $signed({{(GRAD_W-DATA_W_DFLT){1'b0}}, v});
  endfunction

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      p[r][0] = win_i[r][0];
      p[r][1] = win_i[r][1];
      p[r][2] = col_i[r];
    end
  end

  assign gx_d =
    (px(p[0][2]) + (px(p[1][2]) <<< 1) + px(p[2][2]))
  - (px(p[0][0]) + (px(p[1][0]) <<< 1) + px(p[2][0]));

  assign gy_d =
    (px(p[2][0]) + (px(p[2][1]) <<< 1) + px(p[2][2]))
  - (px(p[0][0]) + (px(p[0][1]) <<< 1) + px(p[0][2]));

  assign ax  = gx_q[GRAD_W-1] ? -gx_q : gx_q;
  assign ay  = gy_q[GRAD_W-1] ? -gy_q : gy_q;
  assign sum = {1'b0, ax} + {1'b0, ay};

  // Any bit above DATA_W set means the sum overflowed the pixel range.
  assign data_d = (|sum[GRAD_W:DATA_W])
                ? {DATA_W{1'b1}}
                : sum[DATA_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gx_q   <= '0;
      gy_q   <= '0;
      v1_q   <= 1'b0;
      l1_q   <= 1'b0;
      v2_q   <= 1'b0;
      fd_q   <= 1'b0;
      data_q <= '0;
    end else if (flush_i) begin
      v1_q <= 1'b0;
      l1_q <= 1'b0;
      v2_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      v1_q <= valid_i;
      l1_q <= last_i;
      v2_q <= v1_q;
      fd_q <= l1_q;
      if (valid_i) begin
        gx_q <= gx_d;
        gy_q <= gy_d;
      end
      if (v1_q) data_q <= data_d;
    end
  end

  assign valid_o      = v2_q;
  assign data_o       = data_q;
  assign frame_done_o = fd_q;

endmodule

// File: rtl/sobel_window_stage.sv
// Column/row counters and 3x2 window feeding
// the two-stage Sobel gradient core.
module sobel_window_stage
  import sobel_pkg::*;
#(
  parameter int IMG_W  = 1920,
  parameter int IMG_H  = 1080,
  parameter int DATA_W = DATA_W_DFLT
) (
  input logic                clk,
  input logic                rst_n,
  input logic                flush,
  sobel_window_stage_if.slave io
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  win_t          win_q, win_d;
  pix_t          col_pix [3];
  logic          col_last, row_last;
  logic          win_ok, last_px;

  // Window row 0 is the oldest image row.
  assign col_pix[0] = io.row2_in;
  assign col_pix[1] = io.row1_in;
  assign col_pix[2] = io.row0_in;

  assign col_last = (col_q == CW'(IMG_W-1));
  assign row_last = (row_q == RW'(IMG_H-1));

  assign win_ok  = io.valid_in
                 & (col_q >= CW'(2))
                 & (row_q >= RW'(2));
  assign last_px = io.valid_in & col_last & row_last;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    win_d = win_q;
    if (io.valid_in) begin
      col_d = col_last ? '0 : col_q + CW'(1);
      if (col_last)
        row_d = row_last ? '0 : row_q + RW'(1);
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = col_pix[r];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '{default: '0};
    end else if (flush) begin
      col_q <= '0;
      row_q <= '0;
      win_q <= '{default: '0};
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      win_q <= win_d;
    end
  end

  sobel_grad_core #(
    .DATA_W (DATA_W)
  ) u_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush),
    .valid_i      (win_ok),
    .last_i       (last_px),
    .win_i        (win_q),
    .col_i        (col_pix),
    .valid_o      (io.valid_out),
    .data_o       (io.data_out),
    .frame_done_o (io.frame_done)
  );

endmodule

// File: tb/tb_sobel_window_stage.sv
// Scoreboard bench for sobel_window_stage
// on an 8x6 image.
module tb_sobel_window_stage;

  localparam int W = 8;
  localparam int H = 6;

  typedef struct {
    logic [15:0] data;
    logic        fd;
    int          cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  sobel_window_stage_if #(.DATA_W(16)) io();

  sobel_window_stage #(
    .IMG_W  (W),
    .IMG_H  (H),
    .DATA_W (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .io    (io)
  );

  always #5 clk = ~clk;

  int          cyc     = 0;
  int          checks  = 0;
  int          fails   = 0;
  int          n_valid = 0;
  int          n_fd    = 0;
  int          img [H][W];
  exp_t        sb [$];
  exp_t        m_e;
  logic [15:0] last_exp = '0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (io.valid_out === 1'b1) begin
      n_valid++;
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL sb_unexpected data=%0d fd=%b cyc=%0d",
                 io.data_out, io.frame_done, cyc);
      end else begin
        m_e      = sb.pop_front();
        last_exp = m_e.data;
        if (io.data_out !== m_e.data ||
            io.frame_done !== m_e.fd || cyc != m_e.cyc) begin
          fails++;
          $display("FAIL sb_out got d=%0d fd=%b cyc=%0d exp d=%0d fd=%b cyc=%0d",
                   io.data_out, io.frame_done, cyc,
                   m_e.data, m_e.fd, m_e.cyc);
        end
      end
    end else if (io.frame_done !== 1'b0) begin
      checks++;
      fails++;
      $display("FAIL fd_without_valid fd=%b cyc=%0d",
               io.frame_done, cyc);
    end
    if (io.frame_done === 1'b1) n_fd++;
  end

  function automatic logic [15:0] sobel_ref(input int r, input int c);
    int gx, gy, s;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r][c-2] + 2*img[r][c-1] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c]);
    if (gx < 0) gx = -gx;
    if (gy < 0) gy = -gy;
    s = gx + gy;
    if (s > 65535) s = 65535;
    return 16'(s);
  endfunction

  task automatic idle();
    @(negedge clk);
    io.valid_in = 1'b0;
  endtask

  task automatic drive(input int r, input int c);
    exp_t e;
    @(negedge clk);
    io.valid_in = 1'b1;
    io.row0_in  = 16'(img[r][c]);
    io.row1_in  = 16'd0;
    io.row2_in  = 16'd0;
    if (r >= 1) io.row1_in = 16'(img[r-1][c]);
    if (r >= 2) io.row2_in = 16'(img[r-2][c]);
    if (r >= 2 && c >= 2) begin
      e.data = sobel_ref(r, c);
      e.fd   = (r == H-1 && c == W-1);
      e.cyc  = cyc + 2;
      sb.push_back(e);
    end
  endtask

  task automatic send_range(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) idle();
      drive(i / W, i % W);
    end
  endtask

  task automatic drain();
    idle();
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic clr();
    n_valid = 0;
    n_fd    = 0;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = int'($urandom_range(0, 65535));
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 3;
    if (io.valid_out !== 1'b0) begin
      fails++;
      $display("FAIL rst_valid got %b exp 0", io.valid_out);
    end
    if (io.data_out !== 16'd0) begin
      fails++;
      $display("FAIL rst_data got %0d exp 0", io.data_out);
    end
    if (io.frame_done !== 1'b0) begin
      fails++;
      $display("FAIL rst_fd got %b exp 0", io.frame_done);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_constant();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 100;
    clr();
    send_range(W*H, 1'b0);
    drain();
    checks += 4;
    if (n_valid != 24) begin
      fails++;
      $display("FAIL const_count got %0d exp 24", n_valid);
    end
    if (n_fd != 1) begin
      fails++;
      $display("FAIL const_fd got %0d exp 1", n_fd);
    end
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL const_left got %0d exp 0", sb.size());
    end
    if (io.data_out !== 16'd0) begin
      fails++;
      $display("FAIL const_hold got %0d exp 0", io.data_out);
    end
  endtask

  task automatic test_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 10 * c;
    clr();
    send_range(W*H, 1'b0);
    drain();
    checks += 3;
    if (n_valid != 24) begin
      fails++;
      $display("FAIL ramp_count got %0d exp 24", n_valid);
    end
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL ramp_left got %0d exp 0", sb.size());
    end
    if (io.data_out !== 16'd80) begin
      fails++;
      $display("FAIL ramp_hold got %0d exp 80", io.data_out);
    end
  endtask

  task automatic test_saturate();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = (c == 0) ? 0 : 65535;
    clr();
    send_range(W*H, 1'b0);
    drain();
    checks += 2;
    if (n_valid != 24 || n_fd != 1) begin
      fails++;
      $display("FAIL sat_count got %0d/%0d exp 24/1", n_valid, n_fd);
    end
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sat_left got %0d exp 0", sb.size());
    end
  endtask

  task automatic test_gaps();
    fill_rand();
    clr();
    send_range(W*H, 1'b1);
    drain();
    checks += 3;
    if (n_valid != 24 || n_fd != 1) begin
      fails++;
      $display("FAIL gap_count got %0d/%0d exp 24/1", n_valid, n_fd);
    end
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL gap_left got %0d exp 0", sb.size());
    end
    if (io.data_out !== last_exp) begin
      fails++;
      $display("FAIL gap_hold got %0d exp %0d", io.data_out, last_exp);
    end
  endtask

  task automatic test_flush();
    int lim;
    fill_rand();
    send_range(3*W + 5, 1'b0);
    @(negedge clk);
    flush       = 1'b1;
    io.valid_in = 1'b1;
    io.row0_in  = 16'(img[3][5]);
    lim = cyc + 1;
    while (sb.size() > 0 && sb[sb.size()-1].cyc >= lim)
      void'(sb.pop_back());
    @(negedge clk);
    flush       = 1'b0;
    io.valid_in = 1'b0;
    #1;
    checks += 2;
    if (io.valid_out !== 1'b0 || io.frame_done !== 1'b0) begin
      fails++;
      $display("FAIL flush_clear got v=%b fd=%b exp 0/0",
               io.valid_out, io.frame_done);
    end
    if (io.data_out !== last_exp) begin
      fails++;
      $display("FAIL flush_hold got %0d exp %0d", io.data_out, last_exp);
    end
    clr();
    fill_rand();
    send_range(W*H, 1'b0);
    drain();
    checks += 2;
    if (n_valid != 24 || n_fd != 1) begin
      fails++;
      $display("FAIL flush_count got %0d/%0d exp 24/1", n_valid, n_fd);
    end
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL flush_left got %0d exp 0", sb.size());
    end
  endtask

  task automatic test_async_reset();
    fill_rand();
    send_range(3*W + 4, 1'b0);
    @(posedge clk);
    #2;
    rst_n       = 1'b0;
    io.valid_in = 1'b0;
    #1;
    checks += 3;
    if (io.valid_out !== 1'b0) begin
      fails++;
      $display("FAIL arst_valid got %b exp 0", io.valid_out);
    end
    if (io.data_out !== 16'd0) begin
      fails++;
      $display("FAIL arst_data got %0d exp 0", io.data_out);
    end
    if (io.frame_done !== 1'b0) begin
      fails++;
      $display("FAIL arst_fd got %b exp 0", io.frame_done);
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    clr();
    fill_rand();
    send_range(W*H, 1'b0);
    drain();
    checks += 2;
    if (n_valid != 24 || n_fd != 1) begin
      fails++;
      $display("FAIL arst_count got %0d/%0d exp 24/1", n_valid, n_fd);
    end
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL arst_left got %0d exp 0", sb.size());
    end
  endtask

  initial begin
    io.valid_in = 1'b0;
    io.row0_in  = '0;
    io.row1_in  = '0;
    io.row2_in  = '0;
    test_reset();
    test_constant();
    test_ramp();
    test_saturate();
    test_gaps();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule

// File: doc/sobel_window_stage.md
SOBEL_WINDOW_STAGE -- requirements
Module: sobel_window_stage

Interface
REQ-001 Parameter IMG_W, default 1920, pixels per image row; equals the row-delay length of the upstream long-delay memtiles.
REQ-002 Parameter IMG_H, default 1080, rows per frame.
REQ-003 Parameter DATA_W, default 16, pixel width.
REQ-004 clk  input  1  single clock; all state on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  synchronous frame restart.
REQ-007 valid_in  input  1  the three row inputs carry one column this cycle.
REQ-008 row0_in  input  DATA_W  current-row pixel, unsigned.
REQ-009 row1_in  input  DATA_W  pixel delayed one row (first long-delay tile output).
REQ-010 row2_in  input  DATA_W  pixel delayed two rows (second long-delay tile output).
REQ-011 valid_out  output  1  data_out holds a valid gradient.
REQ-012 data_out  output  DATA_W  saturated |gx|+|gy|.
REQ-013 frame_done  output  1  one-cycle pulse at the last pixel of a frame.

Function
REQ-014 Column counter col (0..IMG_W-1) SHALL increment on each valid_in cycle; at IMG_W-1 it SHALL wrap to 0 and increment row counter row (0..IMG_H-1).
REQ-015 At col=IMG_W-1 and row=IMG_H-1 with valid_in, both counters SHALL wrap to 0, and frame_done SHALL pulse two cycles later, aligned with that pixel's output.
REQ-016 Window: a 3x2 register array holding the two previous columns SHALL shift on valid_in only; the incoming column is the third window column.
REQ-017 gx = (p[0][2]+2p[1][2]+p[2][2]) - (p[0][0]+2p[1][0]+p[2][0]); gy = (p[2][0]+2p[2][1]+p[2][2]) - (p[0][0]+2p[0][1]+p[0][2]); row index 0=row2_in (oldest), column index 2=newest; 20-bit signed.
REQ-018 Stage 1 SHALL register gx, gy and a valid bit; stage 2 SHALL register min(|gx|+|gy|, 2^DATA_W-1) and valid_out.
REQ-019 Latency: valid_in in cycle t yields valid_out/data_out in cycle t+2; no backpressure; pipeline advances every cycle.
REQ-020 valid_out SHALL be asserted only for inputs with col>=2 and row>=2; stale columns after a row wrap SHALL never produce output.
REQ-021 valid_in low SHALL insert a bubble: counters and window hold, stage valids go low.
REQ-022 flush SHALL clear counters, window, stage valids and frame_done on the next edge; flush has priority over a coincident valid_in (that input is dropped).
REQ-023 data_out SHALL hold its last value while valid_out is low.

Reset
REQ-024 rst_n low SHALL asynchronously clear col, row, window, both pipeline stages, valid_out, data_out and frame_done to 0.
REQ-025 Reset release mid-frame SHALL restart at col=0, row=0; no output is produced before two full rows are received.

Structure
REQ-026 Package sobel_pkg SHALL hold DATA_W default, GRAD_W=20, the saturation constant and the window typedef.
REQ-027 The gradient arithmetic and saturation (REQ-017/018) SHALL be one sub-module, sobel_grad_core; counters and window remain in the top.

Verification (bench uses IMG_W=8, IMG_H=6)
REQ-028 Constant field of 100 for a full frame -> 24 valid_out pulses, all data_out=0, frame_done once.
REQ-029 Horizontal ramp pixel=10*col -> every valid output is 80 (|gx|=80, gy=0).
REQ-030 Left column 0 and remaining columns 65535 -> first valid output of each row is 65535 (saturated); later outputs are 0.
REQ-031 valid_in toggled every other cycle -> same output values as a gap-free run, each exactly 2 cycles after its input.
REQ-032 Assert flush at row=3, col=5 -> no output until two new full rows arrive; first output at row=2, col=2 of the restarted frame.
REQ-033 Drop rst_n asynchronously mid-row -> all outputs read 0 immediately, before the next clock edge; after release, behaviour is identical to a fresh frame.
